// File: rtl/awb_gain.sv
// ============================================================================
// Module   : awb_gain
// Purpose  : Grey-world auto white balance. Sums R/G/B per frame, then divides
//            to derive R and B gains (unsigned Q6.10) relative to G.
//            Optional macro AWB_GAIN_CLAMP_EN clamps gains to [0x200, 0x800].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module awb_gain #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 16,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIXEL_WIDTH*3-1:0]   di_i,
  input  logic                       de_i,
  input  logic                       hs_i,
  input  logic                       vs_i,
  output logic [COE_WIDTH*3-1:0]     coe_o,
  output logic                       coe_vld_o,
  output logic                       busy_o
);

  localparam logic [COE_WIDTH-1:0] GAIN_ONE = COE_WIDTH'(16'h0400);

  typedef enum logic [1:0] {IDLE, ACC, DIV, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic                   vs_q;
  logic [SUM_WIDTH-1:0]   sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]   rem_q, rem_d;
  logic [15:0]            shreg_q, shreg_d;
  logic [15:0]            quo_q, quo_d;
  logic                   sat_q, sat_d, zero_q, zero_d;
  logic [COE_WIDTH-1:0]   gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic [COE_WIDTH*3-1:0] coe_q, coe_d;
  logic                   coe_vld_q, coe_vld_d;

  logic [SUM_WIDTH-1:0]   w_divisor;
  logic [SUM_WIDTH:0]     w_trial, w_diff;
  logic                   w_ge;
  logic                   unused_ok;

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] s,
                                                   input logic [PIXEL_WIDTH-1:0] p);
    logic [SUM_WIDTH:0] t;
    t = {1'b0, s} + {{(SUM_WIDTH+1-PIXEL_WIDTH){1'b0}}, p};
    return t[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : t[SUM_WIDTH-1:0];
  endfunction

  function automatic logic [COE_WIDTH-1:0] final_gain(input logic zero, input logic sat,
                                                      input logic [15:0] q);
    logic [15:0] g;
    g = zero ? 16'h0400 : (sat ? 16'hFFFF : q);
`ifdef AWB_GAIN_CLAMP_EN
    if (g < 16'h0200)
      g = 16'h0200;
    else if (g > 16'h0800)
      g = 16'h0800;
`endif
    return COE_WIDTH'(g);
  endfunction

  // Division schedule: cnt 0 is a pad clock, 1..17 is R, 18..34 is B.
  assign w_divisor = (cnt_q < 6'd18) ? sum_r_q : sum_b_q;
  assign w_trial   = {rem_q, shreg_q[15]};
  assign w_ge      = w_trial >= {1'b0, w_divisor};
  assign w_diff    = w_trial - {1'b0, w_divisor};
  assign unused_ok = ^{hs_i, w_diff[SUM_WIDTH]};

  always_comb begin
    state_d   = state_q;
    sum_r_d   = sum_r_q;
    sum_g_d   = sum_g_q;
    sum_b_d   = sum_b_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    shreg_d   = shreg_q;
    quo_d     = quo_q;
    sat_d     = sat_q;
    zero_d    = zero_q;
    gain_r_d  = gain_r_q;
    gain_b_d  = gain_b_q;
    coe_d     = coe_q;
    coe_vld_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vs_i && !vs_q) begin
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (!vs_i) begin
          cnt_d   = '0;
          state_d = DIV;
        end else if (de_i) begin
          sum_b_d = sat_add(sum_b_q, di_i[0 +: PIXEL_WIDTH]);
          sum_g_d = sat_add(sum_g_q, di_i[PIXEL_WIDTH +: PIXEL_WIDTH]);
          sum_r_d = sat_add(sum_r_q, di_i[2*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
      end
      DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd1 || cnt_q == 6'd18) begin
          // Quotient fits 16 bits only when sumG < sumX*64; else force 0xFFFF.
          sat_d   = {6'b0, sum_g_q} >= {w_divisor, 6'b0};
          zero_d  = (w_divisor == '0);
          rem_d   = sum_g_q >> 6;
          shreg_d = {sum_g_q[5:0], 10'b0};
          quo_d   = '0;
        end else if (cnt_q != 6'd0) begin
          rem_d   = w_ge ? w_diff[SUM_WIDTH-1:0] : w_trial[SUM_WIDTH-1:0];
          shreg_d = {shreg_q[14:0], 1'b0};
          quo_d   = {quo_q[14:0], w_ge};
          if (cnt_q == 6'd17)
            gain_r_d = final_gain(zero_q, sat_q, quo_d);
          if (cnt_q == 6'd34) begin
            gain_b_d = final_gain(zero_q, sat_q, quo_d);
            state_d  = UPDATE;
          end
        end
      end
      UPDATE: begin
        coe_d     = {gain_r_q, GAIN_ONE, gain_b_q};
        coe_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vs_q      <= 1'b1;  // a frame already in progress at release is not measured
      sum_r_q   <= '0;
      sum_g_q   <= '0;
      sum_b_q   <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      quo_q     <= '0;
      sat_q     <= 1'b0;
      zero_q    <= 1'b0;
      gain_r_q  <= GAIN_ONE;
      gain_b_q  <= GAIN_ONE;
      coe_q     <= {3{GAIN_ONE}};
      coe_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_i;
      sum_r_q   <= sum_r_d;
      sum_g_q   <= sum_g_d;
      sum_b_q   <= sum_b_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      shreg_q   <= shreg_d;
      quo_q     <= quo_d;
      sat_q     <= sat_d;
      zero_q    <= zero_d;
      gain_r_q  <= gain_r_d;
      gain_b_q  <= gain_b_d;
      coe_q     <= coe_d;
      coe_vld_q <= coe_vld_d;
    end
  end

  assign coe_o     = coe_q;
  assign coe_vld_o = coe_vld_q;
  assign busy_o    = (state_q == DIV) || (state_q == UPDATE);

endmodule

`default_nettype wire

// File: tb/tb_awb_gain.sv
// ============================================================================
// Module   : tb_awb_gain
// Purpose  : Directed self-checking bench for awb_gain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_awb_gain;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] di_i;
  logic        de_i, hs_i, vs_i;
  logic [47:0] coe_o;
  logic        coe_vld_o, busy_o;

  int n_cmp  = 0;
  int n_err  = 0;
  int pulses = 0;
  int p0;

  localparam logic [47:0] ALL_ONE = {16'h0400, 16'h0400, 16'h0400};
  localparam logic [47:0] RES_A   = {16'h0800, 16'h0400, 16'h0202};
  localparam logic [47:0] RES_H   = {16'h0200, 16'h0400, 16'h0200};
`ifdef AWB_GAIN_CLAMP_EN
  localparam logic [47:0] RES_Z   = {16'h0400, 16'h0400, 16'h0800};
`else
  localparam logic [47:0] RES_Z   = {16'h0400, 16'h0400, 16'hFFFF};
`endif

  awb_gain #(.PIXEL_WIDTH(8), .COE_WIDTH(16), .SUM_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .di_i     (di_i),
    .de_i     (de_i),
    .hs_i     (hs_i),
    .vs_i     (vs_i),
    .coe_o    (coe_o),
    .coe_vld_o(coe_vld_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (coe_vld_o === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // vs_i high, n pixels (optionally DE every other clock), then vs_i low.
  task automatic frame(input int n, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit alt);
    @(negedge clk); vs_i = 1'b1; de_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); de_i = 1'b1; di_i = {r, g, b}; hs_i = 1'b0;
      if (alt) begin @(negedge clk); de_i = 1'b0; end
    end
    @(negedge clk); de_i = 1'b0; vs_i = 1'b0;
  endtask

  // Called right after vs_i drops; the next posedge is the end-of-frame sample.
  task automatic wait_update(input string tag, input logic [47:0] exp);
    int k;
    int p;
    k = 0;
    @(posedge clk); #1;
    p = pulses;
    check({tag, "_busy_div"}, {63'd0, busy_o}, 64'd1);
    while (k < 60 && coe_vld_o !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd36);
    check({tag, "_coe"}, {16'd0, coe_o}, {16'd0, exp});
    @(posedge clk); #1;
    check({tag, "_vld_one_cycle"}, {63'd0, coe_vld_o}, 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_pulse_count"}, 64'(pulses - p), 64'd1);
  endtask

  initial begin
    rst = 1'b1; vs_i = 1'b0; de_i = 1'b0; hs_i = 1'b0; di_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_coe", {16'd0, coe_o}, {16'd0, ALL_ONE});
    check("reset_vld", {63'd0, coe_vld_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Pixels with vs_i low must not reach the sums.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); de_i = 1'b1; di_i = 24'hFF0000;
    end
    @(negedge clk); de_i = 1'b0;

    // Grey frame, 64x64 with DE every other clock.
    frame(64*64, 8'h80, 8'h80, 8'h80, 1'b1);
    wait_update("grey", ALL_ONE);

    frame(16*16, 8'h40, 8'h80, 8'hFF, 1'b0);
    wait_update("ratio", RES_A);

    frame(16*16, 8'h00, 8'h80, 8'h01, 1'b0);
    wait_update("zero_sat", RES_Z);

    // Frame-active period with no valid pixels.
    @(negedge clk); vs_i = 1'b1; de_i = 1'b0;
    repeat (20) @(negedge clk);
    vs_i = 1'b0;
    wait_update("empty", ALL_ONE);

    // Back-to-back: second frame rises during DIV and must be skipped.
    frame(16*16, 8'h40, 8'h80, 8'hFF, 1'b0);
    p0 = pulses;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 10) vs_i = 1'b1;
      if (c >= 10 && c < 299) begin de_i = 1'b1; di_i = {8'h80, 8'h40, 8'h80}; end
      if (c == 299) begin de_i = 1'b0; vs_i = 1'b0; end
    end
    check("b2b_first_pulse", 64'(pulses - p0), 64'd1);
    check("b2b_first_coe", {16'd0, coe_o}, {16'd0, RES_A});
    repeat (60) @(negedge clk);
    check("b2b_no_second_pulse", 64'(pulses - p0), 64'd1);
    check("b2b_coe_hold", {16'd0, coe_o}, {16'd0, RES_A});

    // Reset 5 clocks into DIV aborts without a pulse.
    frame(16*16, 8'h80, 8'h40, 8'h80, 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    p0 = pulses;
    #1;
    check("abort_coe", {16'd0, coe_o}, {16'd0, ALL_ONE});
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_vld", {63'd0, coe_vld_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_pulse", 64'(pulses - p0), 64'd0);

    frame(16*16, 8'h80, 8'h40, 8'h80, 1'b0);
    wait_update("after_abort", RES_H);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
